// File: rtl/dmem_stage_responder.sv
// MEM-stage responder: wait-stated word memory behind EX/MEM, registered MEM/WB outputs.
// Define MISALIGN_TRAP_EN to add a sticky misalign output that traps unaligned accesses.
module dmem_stage_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        regWriteIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic        memToRegIn,
    input  logic [31:0] addressIn,
    input  logic [31:0] dataIn,
    input  logic [4:0]  destIn,
    output logic        stall,
    output logic        regWrite,
    output logic        memToReg,
    output logic [31:0] readData,
    output logic [31:0] aluResult,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [4:0]  dest
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam bit         MULTI    = (LATENCY > 1);
    localparam logic [3:0] CNT_INIT = MULTI ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        regWrite_q, regWrite_d;
    logic        memToReg_q, memToReg_d;
    logic [31:0] readData_q, readData_d;
    logic [31:0] aluResult_q, aluResult_d;
    logic [4:0]  dest_q, dest_d;

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             mem_op;
    logic             is_load;
    logic             complete;
    logic             misal;
    logic             mem_we;

    assign idx     = addressIn[IDX_W+1:2];
    assign mem_op  = memReadIn | memWriteIn;
    // A combined read+write request is treated as a store.
    assign is_load = memReadIn & ~memWriteIn;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign misal    = mem_op & (addressIn[1:0] != 2'b00);
    assign misalign = misalign_q;
`else
    assign misal = 1'b0;
`endif

    // The completing cycle is the only cycle in which inputs are sampled.
    assign complete = ((state_q == IDLE) && (!mem_op || !MULTI)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));
    assign stall    = rst & ~complete;
    assign mem_we   = rst & complete & memWriteIn & ~misal;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        regWrite_d  = 1'b0;
        memToReg_d  = 1'b0;
        readData_d  = 32'd0;
        aluResult_d = 32'd0;
        dest_d      = 5'd0;
`ifdef MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
`endif
        if (complete) begin
            state_d     = IDLE;
            regWrite_d  = regWriteIn & ~(is_load & misal);
            memToReg_d  = memToRegIn;
            aluResult_d = addressIn;
            dest_d      = destIn;
            if (is_load && !misal) begin
                readData_d = mem_q[idx];
            end
`ifdef MISALIGN_TRAP_EN
            if (misal) begin
                misalign_d = 1'b1;
            end
`endif
        end else if (state_q == IDLE) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            regWrite_q  <= 1'b0;
            memToReg_q  <= 1'b0;
            readData_q  <= 32'd0;
            aluResult_q <= 32'd0;
            dest_q      <= 5'd0;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            regWrite_q  <= regWrite_d;
            memToReg_q  <= memToReg_d;
            readData_q  <= readData_d;
            aluResult_q <= aluResult_d;
            dest_q      <= dest_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    // Memory contents survive reset; writes are gated by rst so an abandoned store never lands.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= dataIn;
        end
    end

    assign regWrite  = regWrite_q;
    assign memToReg  = memToReg_q;
    assign readData  = readData_q;
    assign aluResult = aluResult_q;
    assign dest      = dest_q;

endmodule

// File: tb/tb_dmem_stage_responder.sv
// Self-checking bench for dmem_stage_responder: LATENCY=2 vector table plus LATENCY=4 reset-abort sequence.
module tb_dmem_stage_responder;

    typedef struct {
        logic        rw, mr, mw, m2r;
        logic [31:0] addr, data;
        logic [4:0]  dst;
        logic [31:0] exp_rd;
        logic        exp_rw;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] rd, alu;
        logic        rw, m2r, mis;
        logic [4:0]  dst;
    } exp_t;

`ifdef MISALIGN_TRAP_EN
    localparam bit MT = 1'b1;
`else
    localparam bit MT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, rst4;
    logic        regWriteIn, memReadIn, memWriteIn, memToRegIn;
    logic [31:0] addressIn, dataIn;
    logic [4:0]  destIn;

    logic        stall2, regWrite2, memToReg2, stall4, regWrite4, memToReg4;
    logic [31:0] readData2, aluResult2, readData4, aluResult4;
    logic [4:0]  dest2, dest4;
`ifdef MISALIGN_TRAP_EN
    logic        mis2, mis4;
`endif

    dmem_stage_responder #(.DEPTH(256), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst2),
        .regWriteIn(regWriteIn), .memReadIn(memReadIn), .memWriteIn(memWriteIn),
        .memToRegIn(memToRegIn), .addressIn(addressIn), .dataIn(dataIn), .destIn(destIn),
        .stall(stall2), .regWrite(regWrite2), .memToReg(memToReg2),
        .readData(readData2), .aluResult(aluResult2),
`ifdef MISALIGN_TRAP_EN
        .misalign(mis2),
`endif
        .dest(dest2)
    );

    dmem_stage_responder #(.DEPTH(256), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst4),
        .regWriteIn(regWriteIn), .memReadIn(memReadIn), .memWriteIn(memWriteIn),
        .memToRegIn(memToRegIn), .addressIn(addressIn), .dataIn(dataIn), .destIn(destIn),
        .stall(stall4), .regWrite(regWrite4), .memToReg(memToReg4),
        .readData(readData4), .aluResult(aluResult4),
`ifdef MISALIGN_TRAP_EN
        .misalign(mis4),
`endif
        .dest(dest4)
    );

    bit          use4;
    logic        stall_s, regWrite_s, memToReg_s;
    logic [31:0] readData_s, aluResult_s;
    logic [4:0]  dest_s;
    assign stall_s     = use4 ? stall4     : stall2;
    assign regWrite_s  = use4 ? regWrite4  : regWrite2;
    assign memToReg_s  = use4 ? memToReg4  : memToReg2;
    assign readData_s  = use4 ? readData4  : readData2;
    assign aluResult_s = use4 ? aluResult4 : aluResult2;
    assign dest_s      = use4 ? dest4      : dest2;
`ifdef MISALIGN_TRAP_EN
    logic mis_s;
    assign mis_s = use4 ? mis4 : mis2;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cur_op = -1;
    exp_t sb[$];
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL op%0d %s actual=%h required=%h", cur_op, name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic mr, input logic mw, input logic m2r,
                                input logic [31:0] addr, input logic [31:0] data, input logic [4:0] dst,
                                input logic [31:0] rd, input logic erw, input logic emis);
        vec_t v;
        v.rw = rw; v.mr = mr; v.mw = mw; v.m2r = m2r;
        v.addr = addr; v.data = data; v.dst = dst;
        v.exp_rd = rd; v.exp_rw = erw; v.exp_mis = emis;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        regWriteIn = v.rw; memReadIn = v.mr; memWriteIn = v.mw; memToRegIn = v.m2r;
        addressIn = v.addr; dataIn = v.data; destIn = v.dst;
    endtask

    task automatic drive_idle();
        drive(mk(0, 0, 0, 0, 32'd0, 32'd0, 5'd0, 32'd0, 0, 0));
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_readData"}, readData_s, 32'd0);
        chk({name, "_aluResult"}, aluResult_s, 32'd0);
        chk({name, "_ctl"}, 32'({regWrite_s, memToReg_s, dest_s}), 32'd0);
    endtask

    // Drives one access, holds it through the stall, then checks the completing edge.
    task automatic run_op(input vec_t v, input int lat);
        int   nst;
        exp_t e;
        exp_t got;
        nst = 0;
        drive(v);
        #1;
        while (stall_s === 1'b1 && nst < 20) begin
            @(posedge clk); #1;
            nst++;
            chk_zero_outputs("bubble");
        end
        chk("stall_cycles", nst, (v.mr | v.mw) ? lat - 1 : 0);
        e.rd = v.exp_rd; e.alu = v.addr; e.rw = v.exp_rw; e.m2r = v.m2r;
        e.dst = v.dst; e.mis = v.exp_mis;
        sb.push_back(e);
        @(posedge clk); #1;
        got = sb.pop_front();
        chk("readData", readData_s, got.rd);
        chk("aluResult", aluResult_s, got.alu);
        chk("regWrite", regWrite_s, got.rw);
        chk("memToReg", memToReg_s, got.m2r);
        chk("dest", dest_s, got.dst);
`ifdef MISALIGN_TRAP_EN
        chk("misalign", mis_s, got.mis);
`endif
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 1, 0, 32'h10,       32'hDEADBEEF, 5'd0,  32'd0,                     0,       0);
        tbl[1]  = mk(1, 1, 0, 1, 32'h10,       32'd0,        5'd5,  32'hDEADBEEF,              1,       0);
        tbl[2]  = mk(1, 0, 0, 0, 32'h1234,     32'd0,        5'd3,  32'd0,                     1,       0);
        tbl[3]  = mk(0, 0, 1, 0, 32'h400,      32'hA5A5A5A5, 5'd0,  32'd0,                     0,       0);
        tbl[4]  = mk(1, 1, 0, 1, 32'h0,        32'd0,        5'd9,  32'hA5A5A5A5,              1,       0);
        tbl[5]  = mk(1, 1, 1, 0, 32'h8,        32'h77,       5'd2,  32'd0,                     1,       0);
        tbl[6]  = mk(1, 1, 0, 1, 32'h8,        32'd0,        5'd4,  32'h77,                    1,       0);
        tbl[7]  = mk(0, 0, 1, 0, 32'h13,       32'h55,       5'd0,  32'd0,                     0,       MT);
        tbl[8]  = mk(1, 1, 0, 1, 32'h10,       32'd0,        5'd8,  MT ? 32'hDEADBEEF : 32'h55, 1,      MT);
        tbl[9]  = mk(1, 1, 0, 1, 32'h13,       32'd0,        5'd6,  MT ? 32'd0 : 32'h55,       !MT,     MT);
        tbl[10] = mk(0, 0, 1, 0, 32'h3FC,      32'h12345678, 5'd0,  32'd0,                     0,       MT);
        tbl[11] = mk(1, 1, 0, 1, 32'h3FC,      32'd0,        5'd31, 32'h12345678,              1,       MT);
        tbl[12] = mk(0, 0, 0, 1, 32'hFFFFFFFF, 32'd0,        5'd0,  32'd0,                     0,       MT);

        // Reset with a pending load on the inputs: stall must still be low.
        rst2 = 1'b0; rst4 = 1'b0; use4 = 1'b0;
        drive(mk(1, 1, 0, 1, 32'h10, 32'd0, 5'd5, 32'd0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            use4 = (d == 1);
            #1;
            chk("reset_stall", stall_s, 1'b0);
            chk_zero_outputs("reset");
`ifdef MISALIGN_TRAP_EN
            chk("reset_misalign", mis_s, 1'b0);
`endif
        end

        use4 = 1'b0;
        drive_idle();
        rst2 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cur_op = i;
            run_op(tbl[i], 2);
        end

        // LATENCY=4 phase: seed 0x20, then abort a store to it with reset.
        drive_idle();
        rst2 = 1'b0;
        use4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b1;
        cur_op = 100;
        run_op(mk(0, 0, 1, 0, 32'h20, 32'h99, 5'd0, 32'd0, 0, 0), 4);
        cur_op = 101;
        run_op(mk(1, 1, 0, 1, 32'h20, 32'd0, 5'd7, 32'h99, 1, 0), 4);

        cur_op = 102;
        drive(mk(0, 0, 1, 0, 32'h20, 32'h11, 5'd0, 32'd0, 0, 0));
        #1;
        chk("abort_stall1", stall_s, 1'b1);
        @(posedge clk); #1;
        chk("abort_stall2", stall_s, 1'b1);
        rst4 = 1'b0;
        #1;
        chk("abort_stall_now", stall_s, 1'b0);
        chk_zero_outputs("abort");
        @(posedge clk); #1;
        chk("abort_stall_held", stall_s, 1'b0);
        drive_idle();
        rst4 = 1'b1;
        cur_op = 103;
        run_op(mk(1, 1, 0, 1, 32'h20, 32'd0, 5'd12, 32'h99, 1, 0), 4);
        cur_op = 104;
        run_op(mk(1, 0, 0, 0, 32'hCAFE0000, 32'd0, 5'd1, 32'd0, 1, 0), 4);

        drive_idle();
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
